// File: rtl/expr_pkg.sv
// expr_pkg
//   Shared definitions for the expression evaluator: ASCII character codes
//   recognised by the character classifier, and the evaluator state encoding.
package expr_pkg;

  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_9    = 8'h39;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_MUL  = 8'h2A;
  localparam logic [7:0] CH_EQ   = 8'h3D;

  typedef enum logic [1:0] {
    S_DIGIT = 2'd0,  // expecting a digit
    S_OP    = 2'd1,  // expecting an operator or '='
    S_DONE  = 2'd2,  // expression complete, waiting for the next one
    S_ERR   = 2'd3   // malformed input seen, absorbing until clr
  } state_t;

endpackage

// File: rtl/expr_eval_char_class.sv
// char_class
//   Purely combinational classifier for one ASCII character.
//   Ports:
//     in[7:0]        ASCII character
//     is_digit       character is '0'..'9'
//     is_plus        character is '+'
//     is_mul         character is '*'
//     is_eq          character is '='
//     digit_val[3:0] numeric value of the digit (0 when not a digit)
module char_class
  import expr_pkg::*;
(
  input  logic [7:0] in,
  output logic       is_digit,
  output logic       is_plus,
  output logic       is_mul,
  output logic       is_eq,
  output logic [3:0] digit_val
);

  // Decode the character class and digit value.
  always_comb begin
    is_digit  = (in >= CH_0) && (in <= CH_9);
    is_plus   = (in == CH_PLUS);
    is_mul    = (in == CH_MUL);
    is_eq     = (in == CH_EQ);
    // '0'..'9' are 8'h30..8'h39, so the low nibble already is the value.
    if (is_digit) begin
      digit_val = in[3:0];
    end else begin
      digit_val = 4'd0;
    end
  end

endmodule

// File: rtl/expr_eval.sv
// expr_eval
//   Evaluates a stream of single-digit ASCII expressions using '+' and '*'
//   ('*' binds tighter), each terminated by '='. Arithmetic wraps modulo
//   2^WIDTH. Malformed input parks the block in a sticky error state.
//   Ports:
//     clk       clock, all state changes on the rising edge
//     clr       synchronous active-high reset (wins over in_valid)
//     in_valid  'in' carries a character this cycle
//     in[7:0]   ASCII character
//     res       value of the last completed expression (registered)
//     done      one-cycle pulse when res is updated (registered)
//     err       sticky malformed-input flag (registered)
//     busy      an expression is partially consumed (registered)
module expr_eval
  import expr_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [7:0]       in,
  output logic [WIDTH-1:0] res,
  output logic             done,
  output logic             err,
  output logic             busy
);

  logic             is_digit_s;
  logic             is_plus_s;
  logic             is_mul_s;
  logic             is_eq_s;
  logic [3:0]       digit_val_s;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] sum_r;
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] term_r;
  logic [WIDTH-1:0] term_s;
  logic             mul_pend_r;
  logic             mul_pend_s;
  logic [WIDTH-1:0] res_r;
  logic [WIDTH-1:0] res_s;
  logic             done_r;
  logic             done_s;
  logic             err_r;
  logic             err_s;
  logic             busy_r;
  logic             busy_s;

  logic [WIDTH-1:0] digit_ext_s;
  logic [WIDTH-1:0] prod_s;
  logic [WIDTH-1:0] sum_term_s;

  char_class u_char_class (
    .in        (in),
    .is_digit  (is_digit_s),
    .is_plus   (is_plus_s),
    .is_mul    (is_mul_s),
    .is_eq     (is_eq_s),
    .digit_val (digit_val_s)
  );

  // Datapath helpers: zero-extended digit, WIDTH x 4 product, running total.
  always_comb begin
    digit_ext_s = {{(WIDTH-4){1'b0}}, digit_val_s};
    prod_s      = term_r * digit_ext_s;
    sum_term_s  = sum_r + term_r;
  end

  // Next-state and next-register logic; idle cycles hold everything but done.
  always_comb begin
    state_s    = state_r;
    sum_s      = sum_r;
    term_s     = term_r;
    mul_pend_s = mul_pend_r;
    res_s      = res_r;
    done_s     = 1'b0;
    busy_s     = busy_r;

    if (in_valid) begin
      case (state_r)
        S_DIGIT: begin
          if (is_digit_s) begin
            term_s  = mul_pend_r ? prod_s : digit_ext_s;
            state_s = S_OP;
          end else begin
            state_s = S_ERR;
          end
        end
        S_OP: begin
          if (is_plus_s) begin
            sum_s      = sum_term_s;
            mul_pend_s = 1'b0;
            state_s    = S_DIGIT;
          end else if (is_mul_s) begin
            mul_pend_s = 1'b1;
            state_s    = S_DIGIT;
          end else if (is_eq_s) begin
            res_s   = sum_term_s;
            done_s  = 1'b1;
            state_s = S_DONE;
          end else begin
            state_s = S_ERR;
          end
        end
        S_DONE: begin
          if (is_digit_s) begin
            sum_s      = {WIDTH{1'b0}};
            mul_pend_s = 1'b0;
            term_s     = digit_ext_s;
            state_s    = S_OP;
          end else begin
            state_s = S_ERR;
          end
        end
        S_ERR: begin
          state_s = S_ERR;
        end
        default: begin
          state_s = S_ERR;
        end
      endcase
      // On a consumed character, S_DIGIT can only be reached through an
      // operator, so both S_OP and S_DIGIT mean "mid-expression" here.
      busy_s = (state_s == S_OP) || (state_s == S_DIGIT);
    end else begin
      state_s = state_r;
    end

    err_s = (state_s == S_ERR);
  end

  // State, datapath and output registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r    <= S_DIGIT;
      sum_r      <= {WIDTH{1'b0}};
      term_r     <= {WIDTH{1'b0}};
      mul_pend_r <= 1'b0;
      res_r      <= {WIDTH{1'b0}};
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      sum_r      <= sum_s;
      term_r     <= term_s;
      mul_pend_r <= mul_pend_s;
      res_r      <= res_s;
      done_r     <= done_s;
      err_r      <= err_s;
      busy_r     <= busy_s;
    end
  end

  assign res  = res_r;
  assign done = done_r;
  assign err  = err_r;
  assign busy = busy_r;

endmodule

// File: tb/tb_expr_eval.sv
// tb_expr_eval
//   Drives two evaluators (WIDTH=16 and WIDTH=8) with the same character
//   stream and compares them with a string-level reference model: the
//   current expression is kept as a character list, checked for the
//   digit/operator alternation, and evaluated as a sum of products.
module tb_expr_eval;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  ch = 8'h00;

  logic [15:0] res16;
  logic        done16, err16, busy16;
  logic [7:0]  res8;
  logic        done8, err8, busy8;

  int checks = 0;
  int failures = 0;

  // reference model state
  byte         mq[$];
  logic        m_err = 1'b0;
  logic        m_done = 1'b0;
  logic        m_busy = 1'b0;
  logic [15:0] m_res16 = 16'd0;
  logic [7:0]  m_res8 = 8'd0;
  int          dcnt16 = 0;
  int          dcnt8 = 0;

  expr_eval #(.WIDTH(16)) dut16 (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in(ch),
    .res(res16), .done(done16), .err(err16), .busy(busy16)
  );

  expr_eval #(.WIDTH(8)) dut8 (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in(ch),
    .res(res8), .done(done8), .err(err8), .busy(busy8)
  );

  always #5 clk = ~clk;

  // Value of a well-formed expression as a sum of digit products, mod mask+1.
  function automatic longint eval_expr(input byte e[$], input longint mask);
    longint sum = 0;
    longint prod = 1;
    for (int i = 0; i < e.size(); i++) begin
      if (e[i] >= "0" && e[i] <= "9") prod = (prod * (e[i] - "0")) & mask;
      else if (e[i] == "+") begin
        sum  = (sum + prod) & mask;
        prod = 1;
      end
    end
    return (sum + prod) & mask;
  endfunction

  // One clock cycle of stimulus; advances the model and tallies done pulses.
  task automatic step(input logic v, input byte c, input logic do_clr);
    bit is_d, is_op;
    int pos;
    in_valid = v;
    ch       = c;
    clr      = do_clr;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr      = 1'b0;
    m_done   = 1'b0;
    if (do_clr) begin
      mq.delete();
      m_err   = 1'b0;
      m_res16 = 16'd0;
      m_res8  = 8'd0;
      dcnt16  = 0;
      dcnt8   = 0;
    end else if (v && !m_err) begin
      pos   = mq.size();
      is_d  = (c >= "0" && c <= "9");
      is_op = (c == "+" || c == "*" || c == "=");
      if ((pos % 2 == 0) ? !is_d : !is_op) begin
        m_err = 1'b1;
        mq.delete();
      end else if (c == "=") begin
        m_res16 = 16'(eval_expr(mq, 64'hFFFF));
        m_res8  = 8'(eval_expr(mq, 64'hFF));
        m_done  = 1'b1;
        mq.delete();
      end else begin
        mq.push_back(c);
      end
    end
    m_busy = (mq.size() > 0);
    if (done16) dcnt16++;
    if (done8) dcnt8++;
  endtask

  task automatic send_str(input string s, input int max_gap);
    for (int i = 0; i < s.len(); i++) begin
      step(1'b1, s[i], 1'b0);
      if (max_gap > 0) begin
        int g = $urandom_range(max_gap, 0);
        for (int k = 0; k < g; k++) step(1'b0, 8'h00, 1'b0);
      end
    end
  endtask

  task automatic test_reset;
    step(1'b0, 8'h00, 1'b1);
    checks++;
    if ({res16, done16, err16, busy16} !== {16'd0, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset16 got res=%0d done=%b err=%b busy=%b exp all 0", res16, done16, err16, busy16);
    end
    checks++;
    if ({res8, done8, err8, busy8} !== {8'd0, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset8 got res=%0d done=%b err=%b busy=%b exp all 0", res8, done8, err8, busy8);
    end
    step(1'b0, 8'h00, 1'b0);
    checks++;
    if (busy16 !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle_busy got=%b exp=0", busy16);
    end
  endtask

  task automatic test_basic;
    step(1'b0, 8'h00, 1'b1);
    send_str("2+3*", 0);
    checks++;
    if (busy16 !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy got=%b exp=1", busy16);
    end
    send_str("4=", 0);
    checks++;
    if ({res16, done16, err16, busy16} !== {16'd14, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL basic_res got res=%0d done=%b err=%b busy=%b exp 14 1 0 0", res16, done16, err16, busy16);
    end
    step(1'b0, 8'h00, 1'b0);
    checks++;
    if (done16 !== 1'b0 || res16 !== 16'd14) begin
      failures++;
      $display("FAIL basic_done_drop got done=%b res=%0d exp 0 14", done16, res16);
    end
  endtask

  task automatic test_gaps;
    step(1'b0, 8'h00, 1'b1);
    send_str("9*9*9*9*9=", 3);
    for (int k = 0; k < 3; k++) step(1'b0, 8'h00, 1'b0);
    checks++;
    if (res16 !== 16'd59049 || dcnt16 != 1 || err16 !== 1'b0) begin
      failures++;
      $display("FAIL gaps16 got res=%0d dones=%0d err=%b exp 59049 1 0", res16, dcnt16, err16);
    end
    checks++;
    if (res8 !== 8'd169 || dcnt8 != 1) begin
      failures++;
      $display("FAIL gaps8 got res=%0d dones=%0d exp 169 1", res8, dcnt8);
    end
  endtask

  task automatic test_width8;
    step(1'b0, 8'h00, 1'b1);
    send_str("9*9*9=", 0);
    checks++;
    if (res8 !== 8'd217 || done8 !== 1'b1 || err8 !== 1'b0) begin
      failures++;
      $display("FAIL width8 got res=%0d done=%b err=%b exp 217 1 0", res8, done8, err8);
    end
    checks++;
    if (res16 !== 16'd729) begin
      failures++;
      $display("FAIL width8_ref16 got res=%0d exp 729", res16);
    end
  endtask

  task automatic test_error;
    step(1'b0, 8'h00, 1'b1);
    send_str("1+", 0);
    step(1'b1, "+", 1'b0);
    checks++;
    if (err16 !== 1'b1 || err8 !== 1'b1 || busy16 !== 1'b0) begin
      failures++;
      $display("FAIL err_rise got err16=%b err8=%b busy=%b exp 1 1 0", err16, err8, busy16);
    end
    send_str("2=", 0);
    for (int k = 0; k < 2; k++) step(1'b0, 8'h00, 1'b0);
    checks++;
    if (err16 !== 1'b1 || res16 !== 16'd0 || dcnt16 != 0) begin
      failures++;
      $display("FAIL err_sticky got err=%b res=%0d dones=%0d exp 1 0 0", err16, res16, dcnt16);
    end
    step(1'b0, 8'h00, 1'b1);
    send_str("4=", 0);
    checks++;
    if (res16 !== 16'd4 || done16 !== 1'b1 || err16 !== 1'b0) begin
      failures++;
      $display("FAIL err_recover got res=%0d done=%b err=%b exp 4 1 0", res16, done16, err16);
    end
  endtask

  task automatic test_back_to_back;
    step(1'b0, 8'h00, 1'b1);
    send_str("5=", 0);
    checks++;
    if (res16 !== 16'd5 || done16 !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first got res=%0d done=%b exp 5 1", res16, done16);
    end
    send_str("7*2+1=", 0);
    checks++;
    if (res16 !== 16'd15 || done16 !== 1'b1 || dcnt16 != 2 || err16 !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second got res=%0d done=%b dones=%0d err=%b exp 15 1 2 0", res16, done16, dcnt16, err16);
    end
    // '==' after a finished expression is malformed
    step(1'b1, "=", 1'b0);
    checks++;
    if (err16 !== 1'b1 || res16 !== 16'd15) begin
      failures++;
      $display("FAIL b2b_eqeq got err=%b res=%0d exp 1 15", err16, res16);
    end
  endtask

  task automatic test_clr_mid;
    step(1'b0, 8'h00, 1'b1);
    send_str("3*4", 0);
    step(1'b1, "+", 1'b1);
    checks++;
    if (busy16 !== 1'b0 || err16 !== 1'b0 || res16 !== 16'd0) begin
      failures++;
      $display("FAIL clr_mid got busy=%b err=%b res=%0d exp 0 0 0", busy16, err16, res16);
    end
    send_str("2=", 0);
    checks++;
    if (res16 !== 16'd2 || done16 !== 1'b1 || err16 !== 1'b0) begin
      failures++;
      $display("FAIL clr_mid_next got res=%0d done=%b err=%b exp 2 1 0", res16, done16, err16);
    end
    // empty expression
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, "=", 1'b0);
    checks++;
    if (err16 !== 1'b1 || done16 !== 1'b0) begin
      failures++;
      $display("FAIL empty_expr got err=%b done=%b exp 1 0", err16, done16);
    end
  endtask

  task automatic test_random;
    byte    s[$];
    string  pool = "+*=9x";
    step(1'b0, 8'h00, 1'b1);
    for (int n = 0; n < 60; n++) begin
      int nterms;
      if (m_err && ($urandom_range(1, 0) == 1)) step(1'b0, 8'h00, 1'b1);
      s.delete();
      nterms = $urandom_range(5, 1);
      for (int t = 0; t < nterms; t++) begin
        s.push_back(byte'("0" + $urandom_range(9, 0)));
        s.push_back((t == nterms - 1) ? "=" : (($urandom_range(1, 0) == 1) ? "*" : "+"));
      end
      if ($urandom_range(7, 0) == 0) s[$urandom_range(s.size() - 1, 0)] = pool[$urandom_range(4, 0)];
      for (int i = 0; i < s.size(); i++) begin
        int g = $urandom_range(2, 0);
        for (int k = 0; k <= g; k++) begin
          if (k == 0) step(1'b1, s[i], 1'b0);
          else step(1'b0, 8'h00, 1'b0);
          checks++;
          if ({res16, res8, done16, done8, err16, err8, busy16, busy8} !==
              {m_res16, m_res8, m_done, m_done, m_err, m_err, m_busy, m_busy}) begin
            failures++;
            $display("FAIL rnd got res16=%0d res8=%0d d=%b%b e=%b%b b=%b%b exp res16=%0d res8=%0d d=%b e=%b b=%b",
                     res16, res8, done16, done8, err16, err8, busy16, busy8,
                     m_res16, m_res8, m_done, m_err, m_busy);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_gaps;
    test_width8;
    test_error;
    test_back_to_back;
    test_clr_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
